// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a valid/ready write port.
// Words are queued in a small FIFO and sent LSB-first as
// start / data / [parity] / stop frames, back-to-back with no idle cycle.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// the data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          s_clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_line,
  output logic                          busy_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic [DATA_W-1:0]   shreg, shreg_next;
  logic                baud_end;
  logic                line_next, busy_next;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level_next;
  logic                push, pop, fifo_empty;
  logic [DATA_W-1:0]   head;

`ifdef UART_TX_PARITY_EN
  logic                par_bit, par_next;
`endif

  assign tx_ready   = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign baud_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // FIFO storage write
  // NOTE: the storage array has no reset; the pointers and level alone
  // decide what is valid, so stale contents are never observed.
  always_ff @(posedge s_clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO level after this edge's push/pop
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LVL_W'(1);
      2'b01:   level_next = fifo_level - LVL_W'(1);
      default: level_next = fifo_level;
    endcase
  end

  // FIFO pointers and level (synchronous reset discards contents)
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
    end
  end

  // State register with baud counter, bit counter, shifter and registered outputs
  // NOTE: every sequential assignment is non-blocking so all registers sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_line   <= 1'b1;
      busy_flag <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      baud_cnt  <= (state == S_IDLE || baud_end) ? '0 : baud_cnt + CNT_W'(1);
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      tx_line   <= line_next;
      busy_flag <= busy_next;
`ifdef UART_TX_PARITY_EN
      par_bit   <= par_next;
`endif
    end
  end

  // Next-state logic: frame sequencing and FIFO pop decisions
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = head;
          bit_next   = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          bit_next   = '0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            shreg_next = shreg >> 1;
            bit_next   = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          bit_next   = '0;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_next = '0;
            // Chain straight into the next frame when more data is queued.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shreg_next = head;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: line level and busy flag for the state being entered
  always_comb begin
    line_next = 1'b1;
`ifdef UART_TX_PARITY_EN
    // Parity of the word is captured when it leaves the FIFO.
    par_next  = pop ? ((^head) ^ (PARITY_ODD != 0)) : par_bit;
`endif
    case (state_next)
      S_IDLE:   line_next = 1'b1;
      S_START:  line_next = 1'b0;
      S_DATA:   line_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_next = par_next;
`endif
      S_STOP:   line_next = 1'b1;
      default:  line_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE) || (level_next != '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (default 8N1/10, 7-bit 2-stop at
// 4 clocks per bit, and the default with PARITY_ODD=1). Stimulus pushes the
// expected serial frame into a per-instance queue; a receiver monitor per
// instance rebuilds frames from tx_line and compares them as they appear.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME0 = (1 + 8 + P + 1) * 10;
  localparam int FRAME1 = (1 + 7 + P + 2) * 4;
  localparam int BUDGET = 3000;

  logic s_clk = 1'b0;
  logic rst_n;
  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic valid0, valid1, valid2;
  logic ready0, ready1, ready2;
  logic line0, line1, line2;
  logic busy0, busy1, busy2;
  logic [2:0] level0, level1, level2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q0[$], exp_q1[$], exp_q2[$];

  always #5 s_clk = ~s_clk;
  always @(posedge s_clk) cyc <= cyc + 1;

  uart_tx_fifo u_dut0 (
    .s_clk(s_clk), .rst_n(rst_n), .data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_line(line0), .busy_flag(busy0), .fifo_level(level0));

  uart_tx_fifo #(.DATA_W(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut1 (
    .s_clk(s_clk), .rst_n(rst_n), .data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_line(line1), .busy_flag(busy1), .fifo_level(level1));

  uart_tx_fifo #(.PARITY_ODD(1)) u_dut2 (
    .s_clk(s_clk), .rst_n(rst_n), .data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .tx_line(line2), .busy_flag(busy2), .fifo_level(level2));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Serial frame, bit 0 first: start, data LSB-first, [parity], stop bits.
  function automatic logic [15:0] make_frame(input logic [8:0] w, input int dw,
                                             input int sb, input bit odd);
    logic [15:0] f;
    logic par;
    int pos;
    f = '0;
    par = odd;
    for (int i = 0; i < dw; i++) begin
      f[1 + i] = w[i];
      par ^= w[i];
    end
    pos = 1 + dw;
    if (P == 1) begin
      f[pos] = par;
      pos++;
    end
    for (int s = 0; s < sb; s++) f[pos + s] = 1'b1;
    return f;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel == 0) ? line0 : (sel == 1) ? line1 : line2;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_q0.size() : (sel == 1) ? exp_q1.size() : exp_q2.size();
  endfunction

  function automatic logic [15:0] qpop(input int sel);
    if (sel == 0) return exp_q0.pop_front();
    if (sel == 1) return exp_q1.pop_front();
    return exp_q2.pop_front();
  endfunction

  // Receiver: detect a start bit, demand each bit is steady for cpb cycles,
  // then compare the whole frame with the oldest expectation.
  task automatic monitor(input int sel, input int cpb, input int nbits);
    logic [15:0] got;
    bit steady, aborted;
    logic v;
    forever begin
      @(posedge s_clk); #1;
      if (rst_n === 1'b1 && line_of(sel) === 1'b0) begin
        got = '0;
        steady = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int c = 0; c < cpb && !aborted; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge s_clk); #1;
            end
            if (rst_n !== 1'b1) aborted = 1'b1;
            else begin
              v = line_of(sel);
              if (c == 0) got[b] = v;
              else if (v !== got[b]) steady = 1'b0;
            end
          end
        end
        if (!aborted) begin
          check($sformatf("bit_hold%0d", sel), 32'(steady), 32'd1);
          if (qsize(sel) == 0) check($sformatf("unexpected_frame%0d", sel), 32'(got), 32'd0);
          else check($sformatf("frame%0d", sel), 32'(got), 32'(qpop(sel)));
        end
      end
    end
  endtask

  // Wait at negedges until busy_flag drops; returns the cycle it was seen low.
  task automatic wait_idle(input int sel, output int t);
    int n;
    n = 0;
    while (busy_of(sel) !== 1'b0 && n < BUDGET) begin
      @(negedge s_clk);
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout%0d got=busy exp=idle at cycle %0d", sel, cyc);
    end
    t = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, t2;
    rst_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    data0 = '0; data1 = '0; data2 = '0;
    fork
      monitor(0, 10, 1 + 8 + P + 1);
      monitor(1, 4, 1 + 7 + P + 2);
      monitor(2, 10, 1 + 8 + P + 1);
    join_none

    // Reset state
    repeat (3) @(negedge s_clk);
    check("rst_line", 32'(line0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_level", 32'(level0), 32'd0);
    rst_n = 1'b1;
    @(negedge s_clk);

    // 1: single 0xA5, one cycle of latency, 100-cycle frame
    data0 = 8'hA5; valid0 = 1'b1; k = cyc + 1;
    exp_q0.push_back(make_frame(9'h0A5, 8, 1, 1'b0));
    @(negedge s_clk);
    valid0 = 1'b0;
    check("lat_line_k", 32'(line0), 32'd1);
    check("lat_busy_k", 32'(busy0), 32'd1);
    @(negedge s_clk);
    check("lat_line_k1", 32'(line0), 32'd0);
    wait_idle(0, t);
    check("a5_length", 32'(t - (k + 1)), 32'(FRAME0));

    // 2: six consecutive writes, fifth fills the FIFO, sixth dropped
    @(negedge s_clk);
    for (int i = 0; i < 6; i++) begin
      data0 = 8'(i + 1); valid0 = 1'b1;
      if (i == 0) k = cyc + 1;
      if (i < 5) exp_q0.push_back(make_frame(9'(i + 1), 8, 1, 1'b0));
      @(negedge s_clk);
      if (i == 4) begin
        check("burst_ready_full", 32'(ready0), 32'd0);
        check("burst_level_full", 32'(level0), 32'd4);
      end
    end
    valid0 = 1'b0;
    check("burst_drop_level", 32'(level0), 32'd4);
    wait_idle(0, t);
    check("burst_length", 32'(t - (k + 1)), 32'(5 * FRAME0));

    // 3: reset 35 cycles into a frame with one word still queued
    @(negedge s_clk);
    data0 = 8'h11; valid0 = 1'b1; k = cyc + 1;
    @(negedge s_clk);
    data0 = 8'h22;
    @(negedge s_clk);
    valid0 = 1'b0;
    while (cyc < k + 35) @(negedge s_clk);
    check("pre_rst_level", 32'(level0), 32'd1);
    check("pre_rst_line", 32'(line0), 32'd0);
    rst_n = 1'b0;
    @(negedge s_clk);
    check("mid_rst_line", 32'(line0), 32'd1);
    check("mid_rst_level", 32'(level0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_ready", 32'(ready0), 32'd1);
    exp_q0.delete();
    rst_n = 1'b1;
    @(negedge s_clk);
    data0 = 8'h3C; valid0 = 1'b1; k = cyc + 1;
    exp_q0.push_back(make_frame(9'h03C, 8, 1, 1'b0));
    @(negedge s_clk);
    valid0 = 1'b0;
    wait_idle(0, t);
    check("post_rst_length", 32'(t - (k + 1)), 32'(FRAME0));

    // 4: 7 data bits, 2 stop bits, 4 clocks per bit
    @(negedge s_clk);
    data1 = 7'h55; valid1 = 1'b1; k = cyc + 1;
    exp_q1.push_back(make_frame(9'h055, 7, 2, 1'b0));
    @(negedge s_clk);
    valid1 = 1'b0;
    wait_idle(1, t);
    check("w7s2_length", 32'(t - (k + 1)), 32'(FRAME1));

    // 5: 0xA5 with even (dut0) and odd (dut2) parity configuration
    @(negedge s_clk);
    data0 = 8'hA5; valid0 = 1'b1;
    data2 = 8'hA5; valid2 = 1'b1; k = cyc + 1;
    exp_q0.push_back(make_frame(9'h0A5, 8, 1, 1'b0));
    exp_q2.push_back(make_frame(9'h0A5, 8, 1, 1'b1));
    @(negedge s_clk);
    valid0 = 1'b0; valid2 = 1'b0;
    wait_idle(0, t);
    wait_idle(2, t2);
    check("par_even_length", 32'(t - (k + 1)), 32'(FRAME0));
    check("par_odd_length", 32'(t2 - (k + 1)), 32'(FRAME0));

    // 6: push on the same edge as the stop-to-start pop at level 2
    @(negedge s_clk);
    for (int i = 0; i < 3; i++) begin
      data0 = 8'h81 >> i; valid0 = 1'b1;
      if (i == 0) k = cyc + 1;
      exp_q0.push_back(make_frame(9'(8'h81 >> i), 8, 1, 1'b0));
      @(negedge s_clk);
    end
    valid0 = 1'b0;
    while (cyc < k + FRAME0) @(negedge s_clk);
    check("pp_pre_level", 32'(level0), 32'd2);
    data0 = 8'h18; valid0 = 1'b1;
    exp_q0.push_back(make_frame(9'h018, 8, 1, 1'b0));
    @(negedge s_clk);
    valid0 = 1'b0;
    check("pp_level", 32'(level0), 32'd2);
    check("pp_ready", 32'(ready0), 32'd1);
    check("pp_b2b_start", 32'(line0), 32'd0);
    wait_idle(0, t);
    check("pp_length", 32'(t - (k + 1)), 32'(4 * FRAME0));

    // All expected frames must have been received
    repeat (5) @(negedge s_clk);
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    check("drain_q2", 32'(exp_q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
